core_result_arbiter: RTL
========================

CORE_RESULT_ARBITER -- requirements
Module: core_result_arbiter

Interface
REQ-001 Parameter N, default 16: base width; point indices and counters are 2N bits.
REQ-002 Parameter CORE_NUMBER, default 16: number of validator cores served.
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pause  input  1  freezes all acknowledges, FIFO writes and counters while high.
REQ-006 point_cloud_size  input  2N  total points to classify; sampled every cycle.
REQ-007 req  input  CORE_NUMBER  bit i high: core i holds a finished result, kept high until acknowledged.
REQ-008 is_outlier  input  CORE_NUMBER  bit i: core i result is an outlier; valid while req[i] is high.
REQ-009 point_idx  input  2N*CORE_NUMBER  slice i: point index held by core i; valid while req[i] is high.
REQ-010 ack  output  CORE_NUMBER  one-cycle pulse per core: result consumed, core may be reloaded.
REQ-011 fifo_din  output  2N  outlier point index to the outlier FIFO.
REQ-012 fifo_wr_en  output  1  one-cycle FIFO write strobe.
REQ-013 fifo_full  input  1  FIFO full; blocks outlier grants.
REQ-014 inlier_count  output  2N  inliers acknowledged so far.
REQ-015 outlier_count  output  2N  outliers acknowledged so far.
REQ-016 all_done  output  1  sticky: every point classified.
REQ-017 fifo_stall_cycles  output  2N  statistics counter (see Configuration).

Function
REQ-018 Two-state FSM, RUN and DONE; reset enters RUN.
REQ-019 Effective request eff[i] = req[i] AND NOT ack[i]; the cycle after an ack pulse does not re-accept the same result.
REQ-020 In RUN with pause low: every core with eff[i] high and is_outlier[i] low gets ack[i] high on the next cycle; any number of inliers per cycle.
REQ-021 In RUN with pause low and fifo_full low: at most one core with eff[i] and is_outlier[i] high is granted per cycle, round-robin.
REQ-022 Round-robin search starts at rr_ptr; after granting core g, rr_ptr becomes (g+1) mod CORE_NUMBER.
REQ-023 rr_ptr holds when no outlier is granted.
REQ-024 An outlier grant registers, next cycle: ack[g]=1, fifo_wr_en=1, fifo_din=point_idx slice g.
REQ-025 fifo_wr_en is low in every cycle without a grant; fifo_din holds its last value.
REQ-026 Latency: request visible at edge t, ack/fifo_wr_en high during cycle t+1.
REQ-027 inlier_count increases by the number of inliers acked in a cycle (popcount), in the same cycle ack rises.
REQ-028 outlier_count increases by 1 per outlier grant, in the same cycle ack rises.
REQ-029 fifo_full high: no outlier granted; inlier acks continue.
REQ-030 pause high: ack and fifo_wr_en are 0 next cycle; counters, rr_ptr and state hold; requests are not lost.
REQ-031 RUN to DONE when inlier_count+outlier_count >= point_cloud_size, evaluated on registered counts.
REQ-032 all_done is high in DONE; DONE exits only on reset.
REQ-033 In DONE no acks or FIFO writes are issued, whatever req is.
REQ-034 point_cloud_size = 0: all_done rises on the first cycle after reset deasserts.
REQ-035 Counters cannot exceed point_cloud_size + CORE_NUMBER; no wrap handling is required.

Reset
REQ-036 Reset values: ack=0, fifo_wr_en=0, fifo_din=0, inlier_count=0, outlier_count=0, all_done=0, fifo_stall_cycles=0, rr_ptr=0, state RUN.
REQ-037 Reset asserted mid-operation overrides pause and discards any in-flight grant; no ack or write in the cycle after reset.

Configuration
REQ-038 Macro CORE_RESULT_ARB_STATS_EN defined: fifo_stall_cycles increments, saturating at all-ones, each RUN cycle with pause low, fifo_full high and at least one outlier eff[i].
REQ-039 Macro CORE_RESULT_ARB_STATS_EN undefined: fifo_stall_cycles is constant 0; the port still exists.

Verification
REQ-040 CORE_NUMBER=4, size=8; req=1111, is_outlier=0000 one cycle -> ack=1111 next cycle, inlier_count=4, fifo_wr_en=0.
REQ-041 req=1111, all outliers, indices 10..13, fifo_full=0 -> writes 10,11,12,13 on four consecutive cycles, outlier_count=4.
REQ-042 After core 2 granted, cores 0 and 3 outliers pending -> core 3 granted before core 0.
REQ-043 fifo_full=1 five cycles with core 1 outlier pending, core 0 inlier -> core 0 acked, no write; with STATS_EN fifo_stall_cycles=5; core 1 written the cycle after full drops.
REQ-044 size=3, three inlier acks -> all_done=1; later req=1111 -> no ack.
REQ-045 pause=1 during pending requests -> no ack for the pause duration; reset during pause -> all outputs at reset values.

Source files
------------

// File: rtl/core_result_arbiter.sv
// core_result_arbiter: collects validator core results, acks inliers in bulk and forwards outliers round-robin to a FIFO.
// Optional stall statistics enabled by defining CORE_RESULT_ARB_STATS_EN.
module core_result_arbiter #(
   parameter int N = 16,
   parameter int CORE_NUMBER = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          pause,
   input  logic [2*N-1:0]                point_cloud_size,
   input  logic [CORE_NUMBER-1:0]        req,
   input  logic [CORE_NUMBER-1:0]        is_outlier,
   input  logic [2*N*CORE_NUMBER-1:0]    point_idx,
   output logic [CORE_NUMBER-1:0]        ack,
   output logic [2*N-1:0]                fifo_din,
   output logic                          fifo_wr_en,
   input  logic                          fifo_full,
   output logic [2*N-1:0]                inlier_count,
   output logic [2*N-1:0]                outlier_count,
   output logic                          all_done,
   output logic [2*N-1:0]                fifo_stall_cycles
);
   localparam int W = 2*N;
   localparam int PW = CORE_NUMBER > 1 ? $clog2(CORE_NUMBER) : 1;
   localparam logic [0:0] RUN = 1'b0;
   localparam logic [0:0] DONE = 1'b1;

   logic [0:0] state;
   logic [PW-1:0] rr_ptr, gnt_idx;
   logic [CORE_NUMBER-1:0] eff, inl, outl, gnt_oh;
   logic [W-1:0] inl_cnt;
   logic [W:0] total;
   logic live, active, gnt;

   function automatic logic [PW-1:0] wrap(input int v);
      return PW'(v % CORE_NUMBER);
   endfunction

   // an ack pulse masks its own request so the held result is not taken twice
   assign eff = req & ~ack;
   assign total = {1'b0, inlier_count} + {1'b0, outlier_count};
   assign live = state == RUN && !pause;
   // once the registered counts cover the cloud, no further results are accepted
   assign active = live && total < {1'b0, point_cloud_size};
   assign inl = active ? eff & ~is_outlier : '0;
   assign outl = eff & is_outlier;
   assign gnt = active && !fifo_full && |outl;
   assign gnt_oh = gnt ? CORE_NUMBER'(1) << gnt_idx : '0;
   assign all_done = state == DONE;

   // descending scan so the nearest core at or after rr_ptr wins
   always_comb begin
      gnt_idx = rr_ptr;
      inl_cnt = '0;
      for (int k = CORE_NUMBER-1; k >= 0; k--) begin
         if (outl[wrap(int'(rr_ptr) + k)]) gnt_idx = wrap(int'(rr_ptr) + k);
         inl_cnt = inl_cnt + W'(inl[k]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RUN;
         rr_ptr <= '0;
         ack <= '0;
         fifo_wr_en <= 1'b0;
         fifo_din <= '0;
         inlier_count <= '0;
         outlier_count <= '0;
      end else begin
         ack <= inl | gnt_oh;
         fifo_wr_en <= gnt;
         if (gnt) begin
            fifo_din <= point_idx[gnt_idx*W +: W];
            rr_ptr <= wrap(int'(gnt_idx) + 1);
         end
         inlier_count <= inlier_count + inl_cnt;
         outlier_count <= outlier_count + W'(gnt);
         if (live && total >= {1'b0, point_cloud_size}) state <= DONE;
      end
   end

`ifdef CORE_RESULT_ARB_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) fifo_stall_cycles <= '0;
      else if (live && fifo_full && |outl && ~&fifo_stall_cycles) fifo_stall_cycles <= fifo_stall_cycles + W'(1);
   end
`else
   assign fifo_stall_cycles = '0;
`endif
endmodule
